// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: the instruction-memory request/response channel,
// the IF/ID head handshake, and the redirect input from execute.
//   master : the fetch queue (drives o_*, samples i_*)
//   slave  : the environment (memory, decode, execute)
interface instr_fetch_queue_if;
  logic        o_imem_req_valid;
  logic [31:0] o_imem_addr;
  logic        i_imem_req_ready;
  logic        i_imem_resp_valid;
  logic [31:0] i_imem_resp_data;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic        i_id_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_addr;
  logic        o_fetch_misalign;

  modport master (
    output o_imem_req_valid, o_imem_addr, o_if_valid, o_if_pc, o_if_instr, o_fetch_misalign,
    input  i_imem_req_ready, i_imem_resp_valid, i_imem_resp_data, i_id_ready,
           i_redirect, i_redirect_addr
  );
  modport slave (
    input  o_imem_req_valid, o_imem_addr, o_if_valid, o_if_pc, o_if_instr, o_fetch_misalign,
    output i_imem_req_ready, i_imem_resp_valid, i_imem_resp_data, i_id_ready,
           i_redirect, i_redirect_addr
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue.
// Issues sequential word fetches, tracks in-flight requests, and buffers the
// in-order responses in a DEPTH-entry queue that feeds the IF/ID register.
// A redirect flushes the queue and drops every response still in flight.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_queue_if.master (imem req/resp, IF head, redirect)
// Optional feature: define FETCH_TRAP_EN to trap misaligned redirects
// (o_fetch_misalign pulse, HALT until an aligned redirect).
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_queue_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0] qwr_q, qwr_d, qrd_q, qrd_d;   // entry queue pointers
  logic [AW-1:0] pwr_q, pwr_d, prd_q, prd_d;   // in-flight PC FIFO pointers
  logic [31:0]   q_pc_q    [DEPTH];
  logic [31:0]   q_instr_q [DEPTH];
  logic [31:0]   pc_fifo_q [DEPTH];

  logic        redir_ok, redir_bad, req_valid, xfer, push, pop, if_valid;
  logic [CW:0] inflight;

`ifdef FETCH_TRAP_EN
  logic misalign_q;
  assign redir_ok = (bus.i_redirect_addr[1:0] == 2'b00);
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= bus.i_redirect & ~redir_ok;
  end
  assign bus.o_fetch_misalign = misalign_q;
`else
  // Low address bits are forced to zero, so they never reach any logic.
  logic unused_addr_lo;
  assign unused_addr_lo       = ^bus.i_redirect_addr[1:0];
  assign redir_ok             = 1'b1;
  assign bus.o_fetch_misalign = 1'b0;
`endif
  assign redir_bad = bus.i_redirect & ~redir_ok;

  // Every outstanding request already owns a queue slot, so an accepted
  // response can always be written without a full check.
  assign inflight  = {1'b0, cnt_q} + {1'b0, out_q};
  assign req_valid = (state_q == FETCH) && !bus.i_redirect && (inflight < (CW+1)'(DEPTH));
  assign xfer      = req_valid && bus.i_imem_req_ready;
  assign push      = bus.i_imem_resp_valid && (drop_q == '0) && !bus.i_redirect;
  assign if_valid  = (cnt_q != '0);
  assign pop       = if_valid && bus.i_id_ready && !bus.i_redirect;

  assign bus.o_imem_req_valid = req_valid;
  assign bus.o_imem_addr      = fetch_pc_q;
  assign bus.o_if_valid       = if_valid;
  assign bus.o_if_pc          = if_valid ? q_pc_q[qrd_q]    : 32'h0;
  assign bus.o_if_instr       = if_valid ? q_instr_q[qrd_q] : 32'h0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    qwr_d      = qwr_q;
    qrd_d      = qrd_q;
    pwr_d      = pwr_q;
    prd_d      = prd_q;

    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (redir_bad) state_d = HALT;
      HALT:    if (bus.i_redirect && redir_ok) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    // Any response retires one outstanding request, accepted or dropped.
    if (xfer && !bus.i_imem_resp_valid)      out_d = out_q + CW'(1);
    else if (!xfer && bus.i_imem_resp_valid) out_d = out_q - CW'(1);

    if (bus.i_redirect) begin
      // No transfer can happen this cycle, so the PC FIFO is simply emptied;
      // the response arriving now is already retired and not counted as drop.
      fetch_pc_d = {bus.i_redirect_addr[31:2], 2'b00};
      drop_d     = out_q - CW'(bus.i_imem_resp_valid);
      cnt_d      = '0;
      qrd_d      = qwr_q;
      prd_d      = pwr_q;
    end else begin
      if (xfer) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pwr_d      = pwr_q + AW'(1);
      end
      if (bus.i_imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        qwr_d = qwr_q + AW'(1);
        prd_d = prd_q + AW'(1);
      end
      if (pop) qrd_d = qrd_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      qwr_q      <= '0;
      qrd_q      <= '0;
      pwr_q      <= '0;
      prd_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      qwr_q      <= qwr_d;
      qrd_q      <= qrd_d;
      pwr_q      <= pwr_d;
      prd_q      <= prd_d;
    end
  end

  // Storage only; validity is carried by the pointers and counts above.
  always_ff @(posedge clk) begin
    if (xfer) pc_fifo_q[pwr_q] <= fetch_pc_q;
    if (push) begin
      q_pc_q[qwr_q]    <= pc_fifo_q[prd_q];
      q_instr_q[qwr_q] <= bus.i_imem_resp_data;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus();
  instr_fetch_queue #(.RESET_PC(32'h0), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: in-order, per-request latency, one response per cycle.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          cyc = 0;
  int          lat = 1;
  bit          rnd_lat = 1'b0;
  logic        mx;
  logic [31:0] ma;

  always @(negedge clk) begin
    mx = !rst && bus.o_imem_req_valid && bus.i_imem_req_ready;
    ma = bus.o_imem_addr;
  end

  always @(posedge clk) begin
    int l;
    cyc++;
    if (rst) mq.delete();
    else if (mx) begin
      l = rnd_lat ? int'($urandom_range(1, 5)) : lat;
      mq.push_back('{ma, cyc + l - 1});
    end
    #1;
    bus.i_imem_resp_valid = 1'b0;
    bus.i_imem_resp_data  = 32'h0;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      bus.i_imem_resp_valid = 1'b1;
      bus.i_imem_resp_data  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Leaves the bench in the first cycle after rst falls (DUT in IDLE).
  task automatic do_reset(input int l, input logic idr);
    rst = 1'b1;
    bus.i_redirect = 1'b0;
    bus.i_imem_req_ready = 1'b1;
    bus.i_id_ready = idr;
    lat = l;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  logic [31:0] exp_pc, prev_pc, prev_instr;
  logic        prev_hold;
  int          n_pop;

  initial begin
    bus.i_imem_req_ready = 1'b1;
    bus.i_id_ready       = 1'b0;
    bus.i_redirect       = 1'b0;
    bus.i_redirect_addr  = 32'h0;

    // Reset state while rst is high
    nxt(); nxt(); smp();
    chk("rst_reqv",  bus.o_imem_req_valid, 0);
    chk("rst_addr",  bus.o_imem_addr, 32'h0);
    chk("rst_ifv",   bus.o_if_valid, 0);
    chk("rst_pc",    bus.o_if_pc, 0);
    chk("rst_instr", bus.o_if_instr, 0);
    chk("rst_mis",   bus.o_fetch_misalign, 0);

    // Sequential fetch, then decode stalled with DEPTH=4
    nxt(); rst = 1'b0; smp();
    chk("c1_reqv", bus.o_imem_req_valid, 0);
    nxt(); smp();
    chk("c2_reqv", bus.o_imem_req_valid, 1);
    chk("c2_addr", bus.o_imem_addr, 32'h0);
    chk("c2_ifv",  bus.o_if_valid, 0);
    nxt(); smp();
    chk("c3_addr", bus.o_imem_addr, 32'h4);
    chk("c3_ifv",  bus.o_if_valid, 0);
    nxt(); smp();
    chk("c4_addr",  bus.o_imem_addr, 32'h8);
    chk("c4_ifv",   bus.o_if_valid, 1);
    chk("c4_pc",    bus.o_if_pc, 32'h0);
    chk("c4_instr", bus.o_if_instr, instr_of(32'h0));
    nxt(); smp();
    chk("c5_reqv", bus.o_imem_req_valid, 1);
    chk("c5_addr", bus.o_imem_addr, 32'hC);
    for (int i = 0; i < 10; i++) begin
      nxt(); smp();
      chk("stall_reqv",  bus.o_imem_req_valid, 0);
      chk("stall_ifv",   bus.o_if_valid, 1);
      chk("stall_pc",    bus.o_if_pc, 32'h0);
      chk("stall_instr", bus.o_if_instr, instr_of(32'h0));
    end
    nxt(); bus.i_id_ready = 1'b1; smp();
    chk("rel_pc0", bus.o_if_pc, 32'h0);
    nxt(); smp();
    chk("rel_pc4", bus.o_if_pc, 32'h4);
    chk("rel_reqv", bus.o_imem_req_valid, 1);
    chk("rel_addr", bus.o_imem_addr, 32'h10);

    // Redirect with two responses in flight (3-cycle memory)
    do_reset(3, 1'b1);
    nxt(); nxt();
    nxt(); bus.i_redirect = 1'b1; bus.i_redirect_addr = 32'h100; smp();
    chk("rd2_reqv_blk", bus.o_imem_req_valid, 0);
    nxt(); bus.i_redirect = 1'b0; smp();
    chk("rd2_reqv", bus.o_imem_req_valid, 1);
    chk("rd2_addr", bus.o_imem_addr, 32'h100);
    chk("rd2_ifv5", bus.o_if_valid, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); smp();
      chk("rd2_ifv_lo", bus.o_if_valid, 0);
    end
    nxt(); smp();
    chk("rd2_ifv",   bus.o_if_valid, 1);
    chk("rd2_pc",    bus.o_if_pc, 32'h100);
    chk("rd2_instr", bus.o_if_instr, instr_of(32'h100));
    nxt(); smp();
    chk("rd2_pc2", bus.o_if_pc, 32'h104);

    // Redirect coinciding with a response and a pop
    do_reset(1, 1'b1);
    nxt(); nxt(); nxt();
    nxt(); bus.i_redirect = 1'b1; bus.i_redirect_addr = 32'h40; smp();
    chk("rdp_pc4",  bus.o_if_pc, 32'h4);
    chk("rdp_reqv", bus.o_imem_req_valid, 0);
    nxt(); bus.i_redirect = 1'b0; smp();
    chk("rdp_ifv",  bus.o_if_valid, 0);
    chk("rdp_reqv2", bus.o_imem_req_valid, 1);
    chk("rdp_addr", bus.o_imem_addr, 32'h40);
    nxt(); smp();
    chk("rdp_ifv2", bus.o_if_valid, 0);
    nxt(); smp();
    chk("rdp_ifv3", bus.o_if_valid, 1);
    chk("rdp_pc",   bus.o_if_pc, 32'h40);

    // Misaligned redirect
    do_reset(1, 1'b1);
    nxt();
    nxt(); bus.i_redirect = 1'b1; bus.i_redirect_addr = 32'h102; smp();
    chk("mis_c0", bus.o_fetch_misalign, 0);
`ifdef FETCH_TRAP_EN
    nxt(); bus.i_redirect = 1'b0; smp();
    chk("mis_pulse", bus.o_fetch_misalign, 1);
    chk("mis_reqv",  bus.o_imem_req_valid, 0);
    chk("mis_ifv",   bus.o_if_valid, 0);
    for (int i = 0; i < 4; i++) begin
      nxt(); smp();
      chk("halt_mis",  bus.o_fetch_misalign, 0);
      chk("halt_reqv", bus.o_imem_req_valid, 0);
    end
    nxt(); bus.i_redirect = 1'b1; bus.i_redirect_addr = 32'h200; smp();
    chk("halt_rd_reqv", bus.o_imem_req_valid, 0);
    nxt(); bus.i_redirect = 1'b0; smp();
    chk("resume_reqv", bus.o_imem_req_valid, 1);
    chk("resume_addr", bus.o_imem_addr, 32'h200);
    chk("resume_mis",  bus.o_fetch_misalign, 0);
`else
    nxt(); bus.i_redirect = 1'b0; smp();
    chk("mis_off",  bus.o_fetch_misalign, 0);
    chk("mis_reqv", bus.o_imem_req_valid, 1);
    chk("mis_addr", bus.o_imem_addr, 32'h100);
    nxt(); smp();
    chk("mis_off2", bus.o_fetch_misalign, 0);
`endif

    // Random latency / ready / decode stalls with periodic redirects
    do_reset(1, 1'b0);
    rnd_lat   = 1'b1;
    exp_pc    = 32'h0;
    prev_hold = 1'b0;
    prev_pc   = 32'h0;
    prev_instr = 32'h0;
    n_pop     = 0;
    for (int i = 0; i < 800; i++) begin
      nxt();
      bus.i_imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.i_id_ready       = ($urandom_range(0, 2) != 0);
      bus.i_redirect       = (i % 97 == 50);
      bus.i_redirect_addr  = 32'h1000 + (i << 4);
      smp();
      if (prev_hold) begin
        chk("hold_ifv",   bus.o_if_valid, 1);
        chk("hold_pc",    bus.o_if_pc, prev_pc);
        chk("hold_instr", bus.o_if_instr, prev_instr);
      end
      if (bus.i_redirect) exp_pc = bus.i_redirect_addr;
      else if (bus.o_if_valid && bus.i_id_ready) begin
        chk("seq_pc",    bus.o_if_pc, exp_pc);
        chk("seq_instr", bus.o_if_instr, instr_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_pop++;
      end
      prev_hold  = bus.o_if_valid && !bus.i_id_ready && !bus.i_redirect;
      prev_pc    = bus.o_if_pc;
      prev_instr = bus.o_if_instr;
    end
    bus.i_redirect = 1'b0;
    chk("rand_progress", 32'(n_pop > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
